id_stage: RTL and testbench

Instruction-decode stage of the RV32I core, between the fetch stage and the execute stage. Accepts one fetched instruction per cycle over a valid/ready handshake, drives rs1/rs2 indices to the register file, resolves same-cycle writeback conflicts, generates the immediate, and holds the result in the ID/EX pipeline register. It supports downstream back-pressure and a flush from branch resolution.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/imm_gen.sv | 34 +++
 rtl/id_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: datapath width, opcodes and immediate formats.
// Used by the decode stage and its immediate generator.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; the sign bit is always instr[31].
// The opcode bits are not needed here because the format is selected by the caller.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  input  imm_type_e   i_type,
  output logic [31:0] o_imm
);

  logic w_s;
  logic w_unused_opc;

  assign w_s          = i_instr[31];
  assign w_unused_opc = ^i_instr[6:0];

  always_comb begin
    o_imm = '0;
    unique case (i_type)
      IMM_I: o_imm = {{20{w_s}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{w_s}}, i_instr[31:25],
                      i_instr[11:7]};
      IMM_B: o_imm = {{19{w_s}}, w_s, i_instr[7],
                      i_instr[30:25], i_instr[11:8],
                      1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{w_s}}, w_s, i_instr[19:12],
                      i_instr[20], i_instr[30:21],
                      1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with ID/EX register, back-pressure and flush.
// ID_WB_BYPASS_EN: forward wb_data_i on a writeback conflict instead of stalling.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [4:0]      rf_rs1_o,
  output logic [4:0]      rf_rs2_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_o,
  output logic [6:0]      ex_opcode_o,
  output logic [2:0]      ex_funct3_o,
  output logic [6:0]      ex_funct7_o,
  output logic            ex_illegal_o
);

  import rv_pkg::*;

  logic [6:0]      w_opc;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_is_lui;
  logic            w_is_auipc;
  logic            w_is_jal;
  logic            w_is_itype;
  logic            w_is_branch;
  logic            w_is_store;
  logic            w_is_op;
  logic            w_is_misc;
  imm_type_e       w_imm_type;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_no_rd;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_stall;
  logic            w_fire;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic [6:0]      r_opc;
  logic [2:0]      r_f3;
  logic [6:0]      r_f7;
  logic            r_ill;

  assign w_opc    = if_instr_i[6:0];
  assign w_rs1    = if_instr_i[19:15];
  assign w_rs2    = if_instr_i[24:20];
  assign rf_rs1_o = w_rs1;
  assign rf_rs2_o = w_rs2;

  assign w_is_lui    = (w_opc == OP_LUI);
  assign w_is_auipc  = (w_opc == OP_AUIPC);
  assign w_is_jal    = (w_opc == OP_JAL);
  assign w_is_itype  = (w_opc == OP_JALR)
                    || (w_opc == OP_LOAD)
                    || (w_opc == OP_OPIMM)
                    || (w_opc == OP_SYSTEM);
  assign w_is_branch = (w_opc == OP_BRANCH);
  assign w_is_store  = (w_opc == OP_STORE);
  assign w_is_op     = (w_opc == OP_OP);
  assign w_is_misc   = (w_opc == OP_MISC);

  always_comb begin
    w_imm_type = IMM_NONE;
    w_use_rs1  = 1'b1;
    w_use_rs2  = 1'b0;
    w_no_rd    = 1'b0;
    w_illegal  = 1'b0;
    unique case (1'b1)
      w_is_lui, w_is_auipc: begin
        w_imm_type = IMM_U;
        w_use_rs1  = 1'b0;
      end
      w_is_jal: begin
        w_imm_type = IMM_J;
        w_use_rs1  = 1'b0;
      end
      w_is_itype: w_imm_type = IMM_I;
      w_is_branch: begin
        w_imm_type = IMM_B;
        w_use_rs2  = 1'b1;
        w_no_rd    = 1'b1;
      end
      w_is_store: begin
        w_imm_type = IMM_S;
        w_use_rs2  = 1'b1;
        w_no_rd    = 1'b1;
      end
      w_is_op:   w_use_rs2 = 1'b1;
      w_is_misc: w_no_rd   = 1'b1;
      default: begin
        w_illegal = 1'b1;
        w_no_rd   = 1'b1;
      end
    endcase
  end

  imm_gen u_imm_gen (
    .i_instr (if_instr_i),
    .i_type  (w_imm_type),
    .o_imm   (w_imm)
  );

  // wb_rd_i != 0 already excludes x0 as a hazard source
  assign w_hit1 = wb_we_i && (wb_rd_i != 5'd0)
               && w_use_rs1 && (w_rs1 == wb_rd_i);
  assign w_hit2 = wb_we_i && (wb_rd_i != 5'd0)
               && w_use_rs2 && (w_rs2 == wb_rd_i);

  // Without bypass the stall blocks any fire on a hit, so the mux is inert
`ifdef ID_WB_BYPASS_EN
  assign w_stall = 1'b0;
`else
  assign w_stall = if_valid_i && (w_hit1 || w_hit2);
`endif

  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_use_rs1)
      w_rs1_val = w_hit1 ? wb_data_i : rf_rs1_data_i;
    if (w_use_rs2)
      w_rs2_val = w_hit2 ? wb_data_i : rf_rs2_data_i;
  end

  assign if_ready_o = !rst_i && !flush_i && !w_stall
                   && (!r_valid || ex_ready_i);
  assign w_fire     = if_valid_i && if_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_opc   <= '0;
      r_f3    <= '0;
      r_f7    <= '0;
      r_ill   <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_pc    <= if_pc_i;
      r_rs1   <= w_rs1_val;
      r_rs2   <= w_rs2_val;
      r_imm   <= w_imm;
      r_rd    <= w_no_rd ? 5'd0 : if_instr_i[11:7];
      r_opc   <= w_opc;
      r_f3    <= if_instr_i[14:12];
      r_f7    <= if_instr_i[31:25];
      r_ill   <= w_illegal;
    end else if (ex_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_pc_o       = r_pc;
  assign ex_rs1_data_o = r_rs1;
  assign ex_rs2_data_o = r_rs2;
  assign ex_imm_o      = r_imm;
  assign ex_rd_o       = r_rd;
  assign ex_opcode_o   = r_opc;
  assign ex_funct3_o   = r_f3;
  assign ex_funct7_o   = r_f7;
  assign ex_illegal_o  = r_ill;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions with hand-computed
// expectations pushed on issue and popped when EX consumes ID/EX.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic [4:0]  rf_rs1_o;
  logic [4:0]  rf_rs2_o;
  logic [31:0] rf_rs1_data_i;
  logic [31:0] rf_rs2_data_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        ex_ready_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rd_o;
  logic [6:0]  ex_opcode_o;
  logic [2:0]  ex_funct3_o;
  logic [6:0]  ex_funct7_o;
  logic        ex_illegal_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .if_valid_i    (if_valid_i),
    .if_ready_o    (if_ready_o),
    .if_instr_i    (if_instr_i),
    .if_pc_i       (if_pc_i),
    .rf_rs1_o      (rf_rs1_o),
    .rf_rs2_o      (rf_rs2_o),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .flush_i       (flush_i),
    .ex_ready_i    (ex_ready_i),
    .ex_valid_o    (ex_valid_o),
    .ex_pc_o       (ex_pc_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rd_o       (ex_rd_o),
    .ex_opcode_o   (ex_opcode_o),
    .ex_funct3_o   (ex_funct3_o),
    .ex_funct7_o   (ex_funct7_o),
    .ex_illegal_o  (ex_illegal_o)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic exp_t mk(
    input logic [31:0] pc, rs1, rs2, imm,
    input logic [4:0] rd, input logic [6:0] op,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.rd = rd; e.op = op;
    e.f3 = f3; e.f7 = f7; e.ill = ill;
    return e;
  endfunction

  // Monitor: EX consumes ID/EX at the next edge when valid && ready
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && ex_valid_o && ex_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ex: got pc %h want none",
                 ex_pc_o);
      end else begin
        e = q.pop_front();
        chk("ex_pc", ex_pc_o, e.pc);
        chk("ex_rs1", ex_rs1_data_o, e.rs1);
        chk("ex_rs2", ex_rs2_data_o, e.rs2);
        chk("ex_imm", ex_imm_o, e.imm);
        chk("ex_rd", {27'd0, ex_rd_o}, {27'd0, e.rd});
        chk("ex_op", {25'd0, ex_opcode_o}, {25'd0, e.op});
        chk("ex_f3", {29'd0, ex_funct3_o}, {29'd0, e.f3});
        chk("ex_f7", {25'd0, ex_funct7_o}, {25'd0, e.f7});
        chk("ex_ill", {31'd0, ex_illegal_o}, {31'd0, e.ill});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] ins, pc, d1, d2);
    if_valid_i    = v;
    if_instr_i    = ins;
    if_pc_i       = pc;
    rf_rs1_data_i = d1;
    rf_rs2_data_i = d2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    ex_ready_i = 1'b1;
    wb_we_i    = 1'b0;
    wb_rd_i    = 5'd0;
    wb_data_i  = 32'd0;
    drive(1'b1, 32'hFFF08293, 32'h100, 32'd10, 32'd0);

    // Reset held two cycles with a valid fetch
    at_neg;
    chk("rst_ready0", {31'd0, if_ready_o}, 32'd0);
    tick;
    at_neg;
    chk("rst_ready1", {31'd0, if_ready_o}, 32'd0);
    chk("rst_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst_pc", ex_pc_o, 32'd0);
    chk("rst_rs1", ex_rs1_data_o, 32'd0);
    chk("rst_rs2", ex_rs2_data_o, 32'd0);
    chk("rst_imm", ex_imm_o, 32'd0);
    chk("rst_fields", {9'd0, ex_rd_o, ex_opcode_o,
        ex_funct3_o, ex_funct7_o, ex_illegal_o}, 32'd0);
    tick;
    rst_i = 1'b0;
    if_valid_i = 1'b0;
    at_neg;
    chk("post_rst_ready", {31'd0, if_ready_o}, 32'd1);

    // ADDI x5,x1,-1
    tick;
    drive(1'b1, 32'hFFF08293, 32'h100, 32'd10, 32'h77);
    at_neg;
    chk("rf_rs1", {27'd0, rf_rs1_o}, 32'd1);
    chk("rf_rs2", {27'd0, rf_rs2_o}, 32'd31);
    chk("addi_ready", {31'd0, if_ready_o}, 32'd1);
    q.push_back(mk(32'h100, 32'd10, 32'd0, 32'hFFFFFFFF,
                   5'd5, 7'h13, 3'd0, 7'h7F, 1'b0));

    // LUI x7,0x12345 back-to-back
    tick;
    drive(1'b1, 32'h123453B7, 32'h104, 32'h5A5, 32'h3C3);
    at_neg;
    q.push_back(mk(32'h104, 32'd0, 32'd0, 32'h12345000,
                   5'd7, 7'h37, 3'd5, 7'h09, 1'b0));

    // Back-pressure: SW x2,8(x1) waits three cycles
    tick;
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h0020A423, 32'h108, 32'h1000, 32'hABCD);
    for (int i = 0; i < 3; i++) begin
      at_neg;
      chk("bp_ready", {31'd0, if_ready_o}, 32'd0);
      chk("bp_pc", ex_pc_o, 32'h104);
      chk("bp_imm", ex_imm_o, 32'h12345000);
      tick;
    end
    ex_ready_i = 1'b1;
    at_neg;
    chk("bp_release", {31'd0, if_ready_o}, 32'd1);
    q.push_back(mk(32'h108, 32'h1000, 32'hABCD, 32'd8,
                   5'd0, 7'h23, 3'd2, 7'h00, 1'b0));

    // Conflict: ADD x3,x1,x2 with writeback to x1
    tick;
    drive(1'b1, 32'h002081B3, 32'h10C, 32'h11, 32'h22);
    wb_we_i   = 1'b1;
    wb_rd_i   = 5'd1;
    wb_data_i = 32'h55;
`ifdef ID_WB_BYPASS_EN
    at_neg;
    chk("byp_ready", {31'd0, if_ready_o}, 32'd1);
    q.push_back(mk(32'h10C, 32'h55, 32'h22, 32'd0,
                   5'd3, 7'h33, 3'd0, 7'h00, 1'b0));
`else
    at_neg;
    chk("stall_ready", {31'd0, if_ready_o}, 32'd0);
    tick;
    wb_we_i = 1'b0;
    rf_rs1_data_i = 32'h55;
    at_neg;
    chk("stall_release", {31'd0, if_ready_o}, 32'd1);
    q.push_back(mk(32'h10C, 32'h55, 32'h22, 32'd0,
                   5'd3, 7'h33, 3'd0, 7'h00, 1'b0));
`endif

    // Writeback to x0 neither bypasses nor stalls
    tick;
    drive(1'b1, 32'h002081B3, 32'h110, 32'h11, 32'h22);
    wb_we_i   = 1'b1;
    wb_rd_i   = 5'd0;
    wb_data_i = 32'h99;
    at_neg;
    chk("wb_x0_ready", {31'd0, if_ready_o}, 32'd1);
    q.push_back(mk(32'h110, 32'h11, 32'h22, 32'd0,
                   5'd3, 7'h33, 3'd0, 7'h00, 1'b0));

    // AUIPC loads, then is flushed along with a fetched JAL
    tick;
    wb_we_i = 1'b0;
    drive(1'b1, 32'h00000217, 32'h114, 32'd0, 32'd0);
    at_neg;
    tick;
    ex_ready_i = 1'b0;
    flush_i    = 1'b1;
    drive(1'b1, 32'h008000EF, 32'h118, 32'h123, 32'h456);
    at_neg;
    chk("flush_ready", {31'd0, if_ready_o}, 32'd0);
    chk("pre_flush_valid", {31'd0, ex_valid_o}, 32'd1);
    tick;
    flush_i    = 1'b0;
    if_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    at_neg;
    chk("flush_kill", {31'd0, ex_valid_o}, 32'd0);
    chk("flush_no_accept", ex_pc_o, 32'h114);

    // JAL x1,8
    tick;
    drive(1'b1, 32'h008000EF, 32'h118, 32'h123, 32'h456);
    at_neg;
    q.push_back(mk(32'h118, 32'd0, 32'd0, 32'd8,
                   5'd1, 7'h6F, 3'd0, 7'h00, 1'b0));

    // BEQ x0,x0,-4
    tick;
    drive(1'b1, 32'hFE000EE3, 32'h11C, 32'd0, 32'd0);
    at_neg;
    q.push_back(mk(32'h11C, 32'd0, 32'd0, 32'hFFFFFFFC,
                   5'd0, 7'h63, 3'd0, 7'h7F, 1'b0));

    // All-zero word is illegal
    tick;
    drive(1'b1, 32'h00000000, 32'h120, 32'd0, 32'h33);
    at_neg;
    q.push_back(mk(32'h120, 32'd0, 32'd0, 32'd0,
                   5'd0, 7'h00, 3'd0, 7'h00, 1'b1));

    // Reset while an instruction sits in ID/EX drops it
    tick;
    drive(1'b1, 32'hFFF08293, 32'h124, 32'd7, 32'd0);
    at_neg;
    tick;
    ex_ready_i = 1'b0;
    if_valid_i = 1'b0;
    rst_i      = 1'b1;
    at_neg;
    chk("pre_rst_valid", {31'd0, ex_valid_o}, 32'd1);
    tick;
    rst_i = 1'b0;
    at_neg;
    chk("mid_rst_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("mid_rst_pc", ex_pc_o, 32'd0);
    tick;
    ex_ready_i = 1'b1;
    repeat (3) tick;
    at_neg;
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
